// File: rtl/con3_pkg.sv
// Shared definitions for the CON3 servo control blocks.
//   ANGLE_W / STEP_W   : widths of the angle code and the per-tick step limit
//   INIT_ANGLE_DEFAULT : servo centre code used after reset
//   ramp_state_t       : slew-limiter FSM states
//   abs_diff           : 9-bit unsigned distance between two angle codes
package con3_pkg;

   localparam int ANGLE_W = 8;
   localparam int STEP_W  = 4;

   localparam logic [ANGLE_W-1:0] INIT_ANGLE_DEFAULT = 8'd128;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } ramp_state_t;

   // Extra bit keeps the full 0..255 distance without any wrap.
   function automatic logic [ANGLE_W:0] abs_diff(input logic [ANGLE_W-1:0] a,
                                                 input logic [ANGLE_W-1:0] b);
      logic [ANGLE_W:0] r;
      if (a > b) r = {1'b0, a} - {1'b0, b};
      else       r = {1'b0, b} - {1'b0, a};
      return r;
   endfunction

endpackage

// File: rtl/con3_angle_ramp_if.sv
// Bus bundle between a target source and con3_angle_ramp.
//   en, target, target_valid, step_size : source -> ramp
//   target_ready, angle, busy, done     : ramp -> source / CON3 PWM driver
interface con3_angle_ramp_if;
   import con3_pkg::*;

   logic               en;
   logic [ANGLE_W-1:0] target;
   logic               target_valid;
   logic               target_ready;
   logic [STEP_W-1:0]  step_size;
   logic [ANGLE_W-1:0] angle;
   logic               busy;
   logic               done;

   modport master (
      output en, target, target_valid, step_size,
      input  target_ready, angle, busy, done
   );

   modport slave (
      input  en, target, target_valid, step_size,
      output target_ready, angle, busy, done
   );

endinterface

// File: rtl/con3_tick_div.sv
// Free-running tick divider for CON3 timing blocks.
//   clk  : system clock
//   rst  : synchronous active-high reset, counter to 0
//   clr  : synchronous clear to 0 (wins over run)
//   run  : count enable; counter holds its value while low
//   tick : high for one cycle when the counter is at TICK_DIV-1 and run is high
module con3_tick_div #(
   parameter int TICK_DIV = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc = (r_cnt == TC);
   assign tick = run & w_tc;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/con3_angle_ramp.sv
// Slew-rate limiter feeding the CON3 servo PWM driver angle input.
// Accepts a target over valid/ready and walks the angle output toward it
// by at most max(step_size,1) per update tick, pulsing done on arrival.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : con3_angle_ramp_if.slave (en, target handshake, step_size,
//         angle, busy, done)
//
//   state | meaning
//   IDLE  | angle at latched target, ready for a new target when en is high
//   RAMP  | stepping angle toward latched target once per tick
module con3_angle_ramp
   import con3_pkg::*;
#(
   parameter int                 TICK_DIV   = 2_000_000,
   parameter logic [ANGLE_W-1:0] INIT_ANGLE = INIT_ANGLE_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   con3_angle_ramp_if.slave   bus
);

   ramp_state_t        r_state;
   ramp_state_t        w_state_nxt;
   logic [ANGLE_W-1:0] r_angle;
   logic [ANGLE_W-1:0] r_target_l;
   logic               r_done;

   logic               w_ready;
   logic               w_busy;
   logic               w_xfer;
   logic               w_run;
   logic               w_tick;
   logic [ANGLE_W:0]   w_step;
   logic [ANGLE_W:0]   w_diff;
   logic               w_last;
   logic               w_up;

   assign w_xfer = bus.target_valid & w_ready;
   assign w_run  = (r_state == RAMP) & bus.en;
   assign w_step = (bus.step_size == '0) ? 9'd1 : {5'd0, bus.step_size};
   assign w_diff = abs_diff(r_target_l, r_angle);
   assign w_last = (w_diff <= w_step);
   assign w_up   = (r_target_l > r_angle);

   con3_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_xfer),
      .run  (w_run),
      .tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_xfer && (bus.target != r_angle)) w_state_nxt = RAMP;
         RAMP: if (w_tick && w_last)                  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      w_busy  = 1'b0;
      case (r_state)
         IDLE: w_ready = bus.en;
         RAMP: w_busy  = 1'b1;
         default: ;
      endcase
   end

   // Angle, latched target and done pulse. done defaults low every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_angle    <= INIT_ANGLE;
         r_target_l <= INIT_ANGLE;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_xfer) begin
            r_target_l <= bus.target;
            if (bus.target == r_angle) r_done <= 1'b1;
         end else if (w_tick) begin
            // A tick only happens in RAMP; the last step lands exactly on target.
            if (w_last) begin
               r_angle <= r_target_l;
               r_done  <= 1'b1;
            end else if (w_up) begin
               r_angle <= r_angle + w_step[ANGLE_W-1:0];
            end else begin
               r_angle <= r_angle - w_step[ANGLE_W-1:0];
            end
         end
      end
   end

   assign bus.target_ready = w_ready;
   assign bus.busy         = w_busy;
   assign bus.angle        = r_angle;
   assign bus.done         = r_done;

endmodule

// File: doc/con3_angle_ramp.md
Name: con3_angle_ramp

Overview:
- Slew-rate limiter that sits directly upstream of the CON3 servo PWM driver and drives its 8-bit angle input.
- Accepts a target angle over a valid/ready handshake, then moves its angle output toward the target by at most step_size per update tick.
- Update ticks come from an internal divider, nominally one tick per 20 ms servo frame.
- Prevents abrupt servo jumps and signals completion with a one-cycle done pulse.

Parameters:
- TICK_DIV, 2_000_000: clk cycles per update tick (20 ms at 100 MHz). Minimum legal value is 2.
- INIT_ANGLE, 8'd128: angle output value after reset (servo centre).

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  enable. Low freezes the FSM, the angle output and the tick divider.
- target  input  8  requested angle code, same scale as the CON3 driver's angle input.
- target_valid  input  1  target is presented.
- target_ready  output  1  block can accept a target; equals (state==IDLE) & en.
- step_size  input  4  maximum angle change per tick. 0 is treated as 1. Sampled at every tick.
- angle  output  8  current commanded angle, registered; connects to the CON3 driver's angle input.
- busy  output  1  high while state==RAMP.
- done  output  1  one-cycle pulse when angle reaches the accepted target.

Behaviour:
- All state is updated on posedge clk. rst overrides en.
- Reset values: angle=INIT_ANGLE, state=IDLE, done=0, busy=0, tick counter=0, latched target=INIT_ANGLE.
- States: IDLE, RAMP.
- Handshake: a transfer occurs in a cycle where target_valid & target_ready are both high.
  - target_ready is low throughout RAMP; new targets are not accepted mid-ramp.
  - The upstream source must hold target stable while valid is high and ready is low.
- IDLE, on transfer:
  - Latch target.
  - Clear the tick counter to 0.
  - If target==angle: stay in IDLE and assert done in the next cycle (1-cycle latency).
  - Otherwise: go to RAMP.
- IDLE, no transfer: angle holds and the tick counter is idle at 0.
- Tick divider:
  - In RAMP with en high, the counter counts 0..TICK_DIV-1.
  - tick is asserted when counter==TICK_DIV-1; the counter wraps to 0 on the same edge.
  - The first tick therefore occurs TICK_DIV cycles after the transfer edge.
- RAMP, on tick. Let s = max(step_size,1) and d = |target_l - angle|, computed in 9-bit unsigned.
  - If d <= s: angle <= target_l, state <= IDLE, done <= 1 on the same edge.
    - done and angle==target_l are visible in the same cycle.
    - target_ready rises in that cycle.
  - Else: angle <= angle + s when target_l > angle, or angle - s when target_l < angle.
    - This never overshoots and never wraps past 0 or 255.
- done is high for exactly one cycle; it is cleared in every cycle not explicitly setting it.
- en low:
  - The tick counter holds its value, angle holds, and state holds.
  - target_ready=0 and done=0.
  - A ramp resumes from the frozen counter value when en returns high.
- Reset mid-RAMP: angle returns to INIT_ANGLE immediately, and the pending target is discarded without a done pulse.
- Boundary cases:
  - target 0 or 255 is reached exactly.
  - step_size of 15 with d=15 finishes in one tick.
  - A target_valid pulse while busy is ignored; no acceptance is implied.

Decomposition:
- Shared package con3_pkg contains:
  - ANGLE_W=8 and STEP_W=4 constants.
  - The ramp_state_t enum {IDLE, RAMP}.
  - The INIT_ANGLE default constant.
- One sub-module, con3_tick_div (parameter TICK_DIV; ports clk, rst, clr, run, tick).
  - Instantiated once for the update tick.
  - Reusable by other CON3 timing blocks.

Test Plan:
All scenarios use TICK_DIV=4.
- Reset check: assert rst 2 cycles, then release -> angle=128, target_ready=1, busy=0, done=0.
- Up-ramp: angle=128, send target=140 with step_size=4 -> angle reads 132, 136, 140 at ticks 4, 8 and 12 cycles after the transfer; done is high for 1 cycle together with angle=140; busy is high from cycle 1 to cycle 11.
- Down-ramp clamp: angle=10, send target=0 with step_size=15 -> a single tick gives angle=0 and a done pulse; no wrap to 251.
- Same-target and step 0: send target equal to the current angle -> no RAMP, done exactly 1 cycle after the transfer. Then send target=3 from 0 with step_size=0 -> angle steps 1, 2, 3.
- Handshake: hold target_valid high with target=200 during an active ramp -> target_ready=0 and the target is not latched; the ramp completes to the original target, and 200 is accepted only in the done cycle.
- en/reset mid-ramp:
  - Drop en for 10 cycles mid-ramp -> angle and counter are frozen, no done; on re-enable the remaining tick spacing is preserved.
  - Assert rst mid-ramp -> angle=128, state=IDLE, no done pulse.
